// File: rtl/bram_s8_arbiter_if.sv
// bram_s8_arbiter_if: request/grant/read-data bundle for the two client ports of bram_s8_arbiter
interface bram_s8_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              a_req, a_we, a_gnt, a_vld;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_di, a_do;
    logic              b_req, b_we, b_gnt, b_vld;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_di, b_do;
    modport master (
        output a_req, a_we, a_addr, a_di, b_req, b_we, b_addr, b_di,
        input  a_gnt, a_vld, a_do, b_gnt, b_vld, b_do
    );
    modport slave (
        input  a_req, a_we, a_addr, a_di, b_req, b_we, b_addr, b_di,
        output a_gnt, a_vld, a_do, b_gnt, b_vld, b_do
    );
endinterface

// File: rtl/bram_s8_arbiter.sv
// bram_s8_arbiter: round-robin two-port arbiter in front of a 512x8 block RAM, with a zero-fill engine
module bram_s8_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk_int,
    input  logic              rst,
    bram_s8_arbiter_if.slave  bus,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic              ram_rst,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do
);
    typedef enum logic {SERVE, CLEAR} state_t;
    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              a_vld_q, b_vld_q, done_q, done_d, serve, clearing;
    logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q;
    logic [DATA_W-1:0] di_q;
    always_ff @(posedge clk_int) begin
        if (rst) begin
            state_q <= SERVE;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            di_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            a_vld_q <= bus.a_gnt & ~bus.a_we;
            b_vld_q <= bus.b_gnt & ~bus.b_we;
            done_q  <= done_d;
            addr_q  <= ram_addr;
            di_q    <= ram_di;
        end
    end
    // ptr_q low means port A wins a conflict; a clear start pre-empts all requests
    always_comb begin
        clearing  = state_q == CLEAR;
        serve     = !clearing && !rst && !clr_start;
        bus.a_gnt = serve & bus.a_req & (~bus.b_req | ~ptr_q);
        bus.b_gnt = serve & bus.b_req & (~bus.a_req | ptr_q);
        ptr_d     = bus.a_gnt ? 1'b1 : bus.b_gnt ? 1'b0 : ptr_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        if (clearing) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d = SERVE;
                done_d  = 1'b1;
            end
        end else if (clr_start) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end
        ram_en   = !rst && (clearing || bus.a_gnt || bus.b_gnt);
        ram_we   = !rst && (clearing || (bus.a_gnt && bus.a_we) || (bus.b_gnt && bus.b_we));
        ram_addr = rst ? '0 : clearing ? cnt_q : bus.a_gnt ? bus.a_addr : bus.b_gnt ? bus.b_addr : addr_q;
        ram_di   = rst || clearing ? '0 : bus.a_gnt ? bus.a_di : bus.b_gnt ? bus.b_di : di_q;
    end
    assign bus.a_vld = a_vld_q & ~rst;
    assign bus.b_vld = b_vld_q & ~rst;
    assign bus.a_do  = ram_do;
    assign bus.b_do  = ram_do;
    assign clr_busy  = state_q == CLEAR;
    assign clr_done  = done_q;
    assign ram_rst   = rst;
endmodule

// File: tb/tb_bram_s8_arbiter.sv
// tb_bram_s8_arbiter: random and directed stimulus checked every cycle against a behavioural arbiter/RAM model
module tb_bram_s8_arbiter;
    logic       clk_int = 1'b0;
    logic       rst = 1'b1, clr_start = 1'b0;
    logic       clr_busy, clr_done, ram_en, ram_we, ram_rst;
    logic [8:0] ram_addr;
    logic [7:0] ram_di, ram_do = 8'h00;
    logic [7:0] mem [512];
    logic [7:0] shadow [512];
    int         vectors = 0, errors = 0;
    bit         go = 1'b0;
    always #5 clk_int = ~clk_int;
    bram_s8_arbiter_if bus ();
    bram_s8_arbiter dut (
        .clk_int(clk_int), .rst(rst), .bus(bus), .clr_start(clr_start),
        .clr_busy(clr_busy), .clr_done(clr_done), .ram_en(ram_en), .ram_we(ram_we),
        .ram_rst(ram_rst), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
    );
    // block RAM: registered read, write-first
    always @(posedge clk_int)
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_di;
                ram_do <= ram_di;
            end else ram_do <= mem[ram_addr];
        end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // reference model: shadow memory, clear progress, priority pointer, pending read
    bit         m_clear = 0, m_ptr = 0, m_pa = 0, m_pb = 0, m_done = 0;
    int         m_cnt = 0;
    logic [7:0] m_pd = 8'h00, m_ld = 8'h00;
    logic [8:0] m_la = 9'h000;
    always @(negedge clk_int) begin : model
        int         w;
        bit         en, we;
        logic [8:0] ea;
        logic [7:0] ed;
        w = -1;
        if (rst) begin
            en = 0; we = 0; ea = 0; ed = 0;
        end else if (m_clear) begin
            en = 1; we = 1; ea = m_cnt[8:0]; ed = 0;
        end else if (clr_start) begin
            en = 0; we = 0; ea = m_la; ed = m_ld;
        end else begin
            if (bus.a_req && bus.b_req) w = m_ptr ? 1 : 0;
            else if (bus.a_req) w = 0;
            else if (bus.b_req) w = 1;
            en = w >= 0;
            we = w == 0 ? bus.a_we : w == 1 ? bus.b_we : 1'b0;
            ea = w == 0 ? bus.a_addr : w == 1 ? bus.b_addr : m_la;
            ed = w == 0 ? bus.a_di : w == 1 ? bus.b_di : m_ld;
        end
        if (go) begin
            chk("a_gnt", bus.a_gnt, w == 0);
            chk("b_gnt", bus.b_gnt, w == 1);
            chk("ram_en", ram_en, en);
            chk("ram_we", ram_we, we);
            chk("ram_addr", ram_addr, ea);
            chk("ram_di", ram_di, ed);
            chk("ram_rst", ram_rst, rst);
            chk("a_vld", bus.a_vld, m_pa && !rst);
            chk("b_vld", bus.b_vld, m_pb && !rst);
            if (m_pa && !rst) chk("a_do", bus.a_do, m_pd);
            if (m_pb && !rst) chk("b_do", bus.b_do, m_pd);
            chk("clr_busy", clr_busy, m_clear);
            chk("clr_done", clr_done, m_done);
        end
        if (rst) begin
            m_clear = 0; m_cnt = 0; m_ptr = 0; m_pa = 0; m_pb = 0; m_done = 0; m_la = 0; m_ld = 0;
        end else begin
            m_pa = 0; m_pb = 0; m_done = 0;
            if (m_clear) begin
                shadow[m_cnt] = 8'h00;
                m_la = ea;
                m_ld = 8'h00;
                if (m_cnt == 511) begin
                    m_clear = 0; m_done = 1; m_cnt = 0;
                end else m_cnt++;
            end else if (clr_start) begin
                m_clear = 1; m_cnt = 0;
            end else if (w >= 0) begin
                if (we) shadow[ea] = ed;
                else begin
                    m_pd = shadow[ea];
                    if (w == 0) m_pa = 1; else m_pb = 1;
                end
                m_ptr = w == 0;
                m_la = ea;
                m_ld = ed;
            end
        end
    end
    task automatic half();
        @(negedge clk_int);
    endtask
    task automatic adv();
        @(posedge clk_int);
        #1;
    endtask
    initial begin
        int  ng, dones;
        bit  seen, done_at_gnt;
        for (int i = 0; i < 512; i++) begin
            mem[i] = 8'($urandom);
            shadow[i] = mem[i];
        end
        {bus.a_req, bus.a_we, bus.b_req, bus.b_we} = '0;
        {bus.a_addr, bus.b_addr, bus.a_di, bus.b_di} = '0;
        repeat (3) @(posedge clk_int);
        #1;
        go = 1;
        half();
        chk("rst_a_gnt", bus.a_gnt, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_busy", clr_busy, 0);
        chk("rst_vld", bus.a_vld, 0);
        adv();
        rst = 0;
        // single-port write then read
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 9'h010; bus.a_di = 8'h5A;
        half();
        chk("t1_wr_gnt", bus.a_gnt, 1);
        adv();
        bus.a_we = 0;
        half();
        chk("t1_rd_gnt", bus.a_gnt, 1);
        adv();
        bus.a_req = 0;
        half();
        chk("t1_vld", bus.a_vld, 1);
        chk("t1_do", bus.a_do, 8'h5A);
        chk("t1_b_vld", bus.b_vld, 0);
        adv();
        // contention alternates A,B,A,B from a fresh pointer
        rst = 1;
        adv();
        rst = 0;
        bus.a_req = 1; bus.b_req = 1; bus.a_we = 0; bus.b_we = 0; bus.a_addr = 9'h010; bus.b_addr = 9'h011;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                bus.a_req = 0; bus.b_req = 0;
            end
            half();
            if (i < 4) begin
                chk("t2_a_gnt", bus.a_gnt, i % 2 == 0);
                chk("t2_b_gnt", bus.b_gnt, i % 2 == 1);
            end
            if (i > 0) begin
                chk("t2_a_vld", bus.a_vld, (i - 1) % 2 == 0);
                chk("t2_b_vld", bus.b_vld, (i - 1) % 2 == 1);
            end
            if (i == 1) chk("t2_a_do", bus.a_do, 8'h5A);
            adv();
        end
        // full clear with A waiting, plus an ignored restart mid-clear
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 9'h1FF; clr_start = 1;
        ng = 0; dones = 0; seen = 0; done_at_gnt = 0;
        for (int k = 0; k < 600 && !seen; k++) begin
            half();
            if (clr_done) dones++;
            if (k == 1 || k == 512) begin
                chk("t3_clr_addr", ram_addr, k - 1);
                chk("t3_clr_we", ram_we, 1);
            end
            if (bus.a_gnt) begin
                seen = 1;
                done_at_gnt = clr_done;
            end else ng++;
            adv();
            clr_start = k == 200;
        end
        chk("t3_nogrant_cycles", ng, 513);
        chk("t3_done_at_gnt", done_at_gnt, 1);
        chk("t3_done_count", dones, 1);
        bus.a_req = 0;
        half();
        chk("t3_vld", bus.a_vld, 1);
        chk("t3_do", bus.a_do, 8'h00);
        chk("t3_done_once", clr_done, 0);
        adv();
        // clear aborted by reset at CLEAR cycle 100
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 9'h050; bus.a_di = 8'h77;
        adv();
        bus.a_addr = 9'h150; bus.a_di = 8'hC3;
        adv();
        bus.a_req = 0; clr_start = 1;
        adv();
        clr_start = 0;
        repeat (100) adv();
        rst = 1;
        half();
        chk("t4_rst_en", ram_en, 0);
        chk("t4_rst_addr", ram_addr, 0);
        adv();
        rst = 0; bus.a_req = 1; bus.a_we = 0; bus.a_addr = 9'h050;
        half();
        chk("t4_busy", clr_busy, 0);
        chk("t4_done", clr_done, 0);
        chk("t4_gnt", bus.a_gnt, 1);
        adv();
        bus.a_addr = 9'h150;
        half();
        chk("t4_vld_050", bus.a_vld, 1);
        chk("t4_do_050", bus.a_do, 8'h00);
        adv();
        bus.a_req = 0;
        half();
        chk("t4_vld_150", bus.a_vld, 1);
        chk("t4_do_150", bus.a_do, 8'hC3);
        adv();
        // reset right after a B read grant
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 9'h150;
        half();
        chk("t5_b_gnt", bus.b_gnt, 1);
        adv();
        bus.b_req = 0; rst = 1;
        half();
        chk("t5_b_vld", bus.b_vld, 0);
        adv();
        rst = 0; bus.a_req = 1; bus.b_req = 1;
        half();
        chk("t5_ptr_a", bus.a_gnt, 1);
        chk("t5_ptr_b", bus.b_gnt, 0);
        adv();
        // random traffic with occasional clears and resets
        for (int n = 0; n < 3000; n++) begin
            bus.a_req = 1'($urandom_range(0, 1));
            bus.b_req = 1'($urandom_range(0, 1));
            bus.a_we = 1'($urandom_range(0, 1));
            bus.b_we = 1'($urandom_range(0, 1));
            bus.a_addr = 9'($urandom_range(0, 511));
            bus.b_addr = 9'($urandom_range(0, 511));
            bus.a_di = 8'($urandom);
            bus.b_di = 8'($urandom);
            clr_start = $urandom_range(0, 399) == 0;
            rst = $urandom_range(0, 499) == 0;
            adv();
        end
        rst = 0; clr_start = 0; bus.a_req = 0; bus.b_req = 0;
        adv();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
